serial_word_rx: RTL and testbench

Receive end of the serial network link. Samples the transmitter-generated `dataClk` strobe and the accompanying serial data line in the local `clk` domain, assembles `WIDTH`-bit words MSB-first, and presents each completed word with a one-cycle valid pulse. A stalled frame is aborted by a watchdog timeout, flagged, and discarded.

---
 rtl/serial_word_rx.sv | 148 ++++++++++++++
 tb/tb_serial_word_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// serial_word_rx
//   Receive end of the serial network link. The transmitter's dataClk strobe
//   and serial data line are synchronised into the clk domain, bits are
//   assembled MSB-first into WIDTH-bit words, and each completed word is
//   presented with a one-cycle rxValid pulse. A frame that stalls for TIMEOUT
//   cycles between strobes is aborted, flagged on frameErr and discarded.
//
// Ports
//   clk       in   system clock, all state on its rising edge
//   rst       in   synchronous active-high reset
//   dataClk   in   serial bit strobe (asynchronous), data valid on its rise
//   serialIn  in   serial data line (asynchronous)
//   rxData    out  last completed word, held until the next one
//   rxValid   out  one-cycle pulse when rxData updates
//   frameErr  out  one-cycle pulse when a partial frame times out
//   busy      out  high while a frame is partially received
//   stateDbg  out  current FSM state (0 = IDLE, 1 = SHIFT)
//
// Output protocol: rxValid is a strobe with no backpressure. rxData is
// qualified by rxValid in the cycle it pulses and then simply holds; there
// is no ready input, so a consumer must capture the word on the pulse.
// rxValid and frameErr are never high together.

module serial_word_rx #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dataClk,
  input  logic             serialIn,
  output logic [WIDTH-1:0] rxData,
  output logic             rxValid,
  output logic             frameErr,
  output logic             busy,
  output logic             stateDbg
);

  localparam int BW = $clog2(WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } stateT;

  stateT            state, stateNxt;
  logic [BW-1:0]    bitCnt, bitCntNxt;
  logic [TW-1:0]    toCnt, toCntNxt;
  logic [WIDTH-1:0] shiftReg, shiftNxt;
  logic [WIDTH-1:0] rxDataNxt;
  logic             rxValidNxt, frameErrNxt;

  // Strobe chain is one flop longer than the data chain so that the data bit
  // seen alongside rise (sS2) has the same delay as the strobe edge (dS2).
  logic dS1, dS2, dS3;
  logic sS1, sS2;
  logic rise;

  assign rise     = dS2 & ~dS3;
  assign busy     = (state == SHIFT);
  assign stateDbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      dS1      <= 1'b0;
      dS2      <= 1'b0;
      dS3      <= 1'b0;
      sS1      <= 1'b0;
      sS2      <= 1'b0;
      state    <= IDLE;
      bitCnt   <= '0;
      toCnt    <= '0;
      shiftReg <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      dS1      <= dataClk;
      dS2      <= dS1;
      dS3      <= dS2;
      sS1      <= serialIn;
      sS2      <= sS1;
      state    <= stateNxt;
      bitCnt   <= bitCntNxt;
      toCnt    <= toCntNxt;
      shiftReg <= shiftNxt;
      rxData   <= rxDataNxt;
      rxValid  <= rxValidNxt;
      frameErr <= frameErrNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    bitCntNxt   = bitCnt;
    toCntNxt    = toCnt;
    shiftNxt    = shiftReg;
    rxDataNxt   = rxData;
    rxValidNxt  = 1'b0;
    frameErrNxt = 1'b0;

    case (state)
      IDLE: begin
        toCntNxt = '0;
        if (rise) begin
          shiftNxt  = {shiftReg[WIDTH-2:0], sS2};
          bitCntNxt = BW'(1);
          stateNxt  = SHIFT;
        end
      end

      SHIFT: begin
        // A strobe always beats the timeout terminal count.
        if (rise) begin
          shiftNxt = {shiftReg[WIDTH-2:0], sS2};
          toCntNxt = '0;
          if (bitCnt == BIT_LAST) begin
            rxDataNxt  = {shiftReg[WIDTH-2:0], sS2};
            rxValidNxt = 1'b1;
            bitCntNxt  = '0;
            stateNxt   = IDLE;
          end else begin
            bitCntNxt = bitCnt + BW'(1);
          end
        end else if (toCnt == TO_LAST) begin
          frameErrNxt = 1'b1;
          bitCntNxt   = '0;
          toCntNxt    = '0;
          stateNxt    = IDLE;
        end else if (toCnt != TO_MAX) begin
          toCntNxt = toCnt + TW'(1);
        end
      end

      default: begin
        stateNxt  = IDLE;
        bitCntNxt = '0;
        toCntNxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx
//   Directed bench for serial_word_rx (WIDTH = 8, TIMEOUT = 20). Inputs are
//   driven 1 time unit after each rising clk edge; outputs are sampled on the
//   falling edge by the scoreboard or 1 unit after a rising edge by the
//   directed checks.

module tb_serial_word_rx;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 20;

  logic             clk;
  logic             rst;
  logic             dataClk;
  logic             serialIn;
  logic [WIDTH-1:0] rxData;
  logic             rxValid;
  logic             frameErr;
  logic             busy;
  logic             stateDbg;

  serial_word_rx #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dataClk  (dataClk),
    .serialIn (serialIn),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .frameErr (frameErr),
    .busy     (busy),
    .stateDbg (stateDbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- checking ----------------
  int checkCnt = 0;
  int passCnt  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt = checkCnt + 1;
    if (got === exp) passCnt = passCnt + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int errCnt = 0;
  int errCyc = 0;
  int riseCyc = 0;

  always @(negedge clk) begin
    if (rxValid) begin
      checkVal("rxExpected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) checkVal("rxData", rxData, exp_q.pop_front());
    end
    if (frameErr) begin
      errCnt = errCnt + 1;
      errCyc = cyc;
    end
    if (rxValid || frameErr) checkVal("validErrExcl", rxValid & frameErr, 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Low phase (data set up) then high phase (strobe).
  task automatic sendBit(input logic b, input int lo, input int hi);
    dataClk  = 1'b0;
    serialIn = b;
    tick(lo);
    dataClk = 1'b1;
    riseCyc = cyc;
    tick(hi);
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w);
    exp_q.push_back(w);
    for (int i = WIDTH - 1; i >= 0; i--) sendBit(w[i], 4, 4);
  endtask

  task automatic idle(input int n);
    dataClk = 1'b0;
    tick(n);
  endtask

  // ---------------- stimulus ----------------
  int bad;
  int e0;
  logic [WIDTH-1:0] w;

  initial begin
    rst      = 1'b1;
    dataClk  = 1'b0;
    serialIn = 1'b0;
    tick(2);

    // Reset state
    checkVal("rstRxData", rxData, 0);
    checkVal("rstRxValid", rxValid, 0);
    checkVal("rstFrameErr", frameErr, 0);
    checkVal("rstBusy", busy, 0);
    rst = 1'b0;

    // Idle: nothing may move with dataClk low
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (rxData !== 0 || rxValid !== 0 || frameErr !== 0 || busy !== 0) bad = bad + 1;
    end
    checkVal("idleQuiet", bad, 0);

    // Single word 0xA5 with latency check on the final bit
    w = 8'hA5;
    exp_q.push_back(w);
    for (int i = WIDTH - 1; i >= 1; i--) sendBit(w[i], 4, 4);
    dataClk  = 1'b0;
    serialIn = w[0];
    tick(4);
    dataClk = 1'b1;             // first sampled by dS1 at edge N
    tick(1);                    // after N
    tick(1);                    // after N+1
    checkVal("latPreValid", rxValid, 0);
    checkVal("latPreBusy", busy, 1);
    checkVal("latStateDbg", stateDbg, 1);
    tick(1);                    // after N+2
    checkVal("latValid", rxValid, 1);
    checkVal("latData", rxData, 8'hA5);
    checkVal("latBusyFall", busy, 0);
    tick(1);                    // after N+3
    checkVal("latValidPulse", rxValid, 0);
    idle(6);

    // Back-to-back words
    e0 = errCnt;
    sendWord(8'h3C);
    sendWord(8'hFF);
    idle(6);
    checkVal("b2bNoErr", errCnt - e0, 0);
    checkVal("b2bData", rxData, 8'hFF);

    // Timeout after 5 bits
    e0 = errCnt;
    sendBit(1'b1, 4, 4);
    sendBit(1'b0, 4, 4);
    sendBit(1'b1, 4, 4);
    sendBit(1'b0, 4, 4);
    sendBit(1'b1, 4, 4);
    idle(30);
    checkVal("toCount", errCnt - e0, 1);
    // rise captured 3 edges after the strobe is raised, error 20 after that
    checkVal("toCycle", errCyc, riseCyc + 3 + TIMEOUT);
    checkVal("toHold", rxData, 8'hFF);
    checkVal("toBusy", busy, 0);
    sendWord(8'h81);
    idle(6);
    checkVal("toRecover", rxData, 8'h81);

    // Race: second strobe 20 cycles after the first lands on toCnt == TIMEOUT-1
    e0 = errCnt;
    w = 8'h5A;
    exp_q.push_back(w);
    sendBit(w[7], 4, 4);
    sendBit(w[6], 16, 4);
    for (int i = WIDTH - 3; i >= 0; i--) sendBit(w[i], 4, 4);
    idle(6);
    checkVal("raceNoErr", errCnt - e0, 0);
    checkVal("raceData", rxData, 8'h5A);

    // Reset mid-frame
    e0 = errCnt;
    for (int i = 0; i < 4; i++) sendBit(1'b1, 4, 4);
    dataClk = 1'b0;
    rst = 1'b1;
    tick(1);
    checkVal("midRstData", rxData, 0);
    checkVal("midRstBusy", busy, 0);
    checkVal("midRstValid", rxValid, 0);
    rst = 1'b0;
    sendWord(8'h0F);
    idle(30);
    checkVal("midRstNoErr", errCnt - e0, 0);
    checkVal("midRstData2", rxData, 8'h0F);

    checkVal("queueDrained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
